// File: rtl/rv_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 hazard/flush controller.
package rv_hazard_ctrl_pkg;

    // Controller operating modes.
    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_FLUSH = 2'd1,
        HZ_FENCE = 2'd2
    } hz_state_t;

    // Architectural zero register index; never pending, never bypassed.
    localparam int unsigned RA_ZERO = 0;

endpackage

// File: rtl/rv_hazard_ctrl_bp_select.sv
// Forwarding select for one source operand against all bypass stages.
module rv_bp_select
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned BP_STAGES = 3,
    parameter int unsigned RA_W      = 5
) (
    input  logic [RA_W-1:0]           rs_i,
    input  logic [BP_STAGES*RA_W-1:0] bp_rd_i,
    input  logic [BP_STAGES-1:0]      bp_we_i,
    output logic [BP_STAGES-1:0]      sel_o
);

    // Youngest matching stage wins: scan oldest to youngest so lower k overrides.
    always_comb begin
        sel_o = '0;
        for (int k = int'(BP_STAGES) - 1; k >= 0; k--) begin
            if (bp_we_i[k] && (bp_rd_i[k*RA_W +: RA_W] == rs_i)) begin
                sel_o    = '0;
                sel_o[k] = 1'b1;
            end
        end
        if (rs_i == RA_W'(RA_ZERO)) begin
            sel_o = '0;
        end
    end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard/flush controller: bypass selects, long-latency scoreboard,
// RUN/FLUSH/FENCE sequencing and the delayed invalid-instruction flag.
module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned BP_STAGES = 3,
    parameter int unsigned RA_W      = 5,
    parameter int unsigned MAX_LONG  = 2,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned INV_DEPTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_pc_change,
    input  logic                      i_decode_valid,
    input  logic                      i_decode_inst_sup,
    input  logic [RA_W-1:0]           i_decode_rs1,
    input  logic [RA_W-1:0]           i_decode_rs2,
    input  logic [RA_W-1:0]           i_decode_rd,
    input  logic                      i_decode_long,
    input  logic                      i_decode_fence,
    input  logic [RA_W-1:0]           i_alu_rs1,
    input  logic [RA_W-1:0]           i_alu_rs2,
    input  logic [BP_STAGES*RA_W-1:0] i_bp_rd,
    input  logic [BP_STAGES-1:0]      i_bp_we,
    input  logic                      i_long_done,
    input  logic [RA_W-1:0]           i_long_rd,
    input  logic                      i_alu2_ready,
    input  logic                      i_need_pause,
    output logic                      o_fetch_stall,
    output logic                      o_decode_stall,
    output logic                      o_decode_flush,
    output logic                      o_alu1_stall,
    output logic                      o_alu1_flush,
    output logic                      o_alu2_flush,
    output logic [BP_STAGES-1:0]      o_rs1_bp,
    output logic [BP_STAGES-1:0]      o_rs2_bp,
    output logic                      o_fence_done,
    output logic                      o_inv_inst
);

    localparam int unsigned NREG  = 2 ** RA_W;
    localparam int unsigned CNT_W = $clog2(MAX_LONG + 1);
    localparam int unsigned FC_W  = $clog2(FLUSH_CYC + 1);

    hz_state_t            state_q, state_d;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic [NREG-1:0]      pend_q, pend_d;
    logic [CNT_W-1:0]     lcnt_q, lcnt_d;
    logic [INV_DEPTH-1:0] inv_q, inv_d;

    logic hz, decode_stall, flush_all, issue, retire, cnt_full, lcnt_zero;

    rv_bp_select #(.BP_STAGES(BP_STAGES), .RA_W(RA_W)) u_bp_rs1 (
        .rs_i    (i_alu_rs1),
        .bp_rd_i (i_bp_rd),
        .bp_we_i (i_bp_we),
        .sel_o   (o_rs1_bp)
    );

    rv_bp_select #(.BP_STAGES(BP_STAGES), .RA_W(RA_W)) u_bp_rs2 (
        .rs_i    (i_alu_rs2),
        .bp_rd_i (i_bp_rd),
        .bp_we_i (i_bp_we),
        .sel_o   (o_rs2_bp)
    );

    // Hazard detection, stall/flush qualification and issue/retire strobes.
    always_comb begin
        cnt_full     = (lcnt_q == CNT_W'(MAX_LONG));
        lcnt_zero    = (lcnt_q == '0);
        hz           = i_decode_valid &
                       (pend_q[i_decode_rs1] | pend_q[i_decode_rs2] |
                        (i_decode_long & (pend_q[i_decode_rd] | cnt_full)));
        decode_stall = i_reset | hz | i_need_pause | ~i_alu2_ready |
                       (state_q != HZ_RUN);
        flush_all    = i_reset | i_pc_change | (state_q == HZ_FLUSH);
        issue        = i_decode_valid & i_decode_long &
                       (i_decode_rd != RA_W'(RA_ZERO)) & ~decode_stall &
                       (state_q == HZ_RUN);
        retire       = i_long_done & pend_q[i_long_rd];
    end

    // Scoreboard and outstanding-count update; flushes leave in-flight ops tracked.
    always_comb begin
        pend_d = pend_q;
        lcnt_d = lcnt_q;
        if (retire) begin
            pend_d[i_long_rd] = 1'b0;
        end
        if (issue) begin
            pend_d[i_decode_rd] = 1'b1;
        end
        pend_d[RA_ZERO] = 1'b0;
        case ({issue, retire})
            2'b10:   lcnt_d = lcnt_q + CNT_W'(1);
            2'b01:   lcnt_d = lcnt_q - CNT_W'(1);
            default: lcnt_d = lcnt_q;
        endcase
    end

    // RUN/FLUSH/FENCE next-state and fence completion pulse.
    always_comb begin
        state_d      = state_q;
        fcnt_d       = fcnt_q;
        o_fence_done = 1'b0;
        case (state_q)
            HZ_RUN: begin
                if (i_pc_change) begin
                    state_d = HZ_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYC);
                end else if (i_decode_valid && i_decode_fence) begin
                    if (lcnt_zero) begin
                        o_fence_done = 1'b1;
                    end else begin
                        state_d = HZ_FENCE;
                    end
                end
            end
            HZ_FLUSH: begin
                if (i_pc_change) begin
                    fcnt_d = FC_W'(FLUSH_CYC);
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                    if (fcnt_q == FC_W'(1)) begin
                        state_d = HZ_RUN;
                    end
                end
            end
            HZ_FENCE: begin
                if (i_pc_change) begin
                    state_d = HZ_FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYC);
                end else if (lcnt_zero) begin
                    o_fence_done = 1'b1;
                    state_d      = HZ_RUN;
                end
            end
            default: begin
                state_d = HZ_FLUSH;
                fcnt_d  = FC_W'(FLUSH_CYC);
            end
        endcase
        if (i_reset) begin
            o_fence_done = 1'b0;
        end
    end

    // Invalid-instruction delay line; a 0 reaching the msb reports the fault.
    always_comb begin
        inv_d = inv_q;
        if (flush_all) begin
            inv_d = '1;
        end else if (!decode_stall) begin
            inv_d = INV_DEPTH'({inv_q, i_decode_inst_sup | ~i_decode_valid});
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= HZ_FLUSH;
            fcnt_q  <= FC_W'(FLUSH_CYC);
            pend_q  <= '0;
            lcnt_q  <= '0;
            inv_q   <= '1;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            lcnt_q  <= lcnt_d;
            inv_q   <= inv_d;
        end
    end

    assign o_decode_stall = decode_stall;
    assign o_fetch_stall  = decode_stall;
    assign o_alu1_stall   = i_reset | ~i_alu2_ready;
    assign o_alu1_flush   = flush_all | (decode_stall & i_alu2_ready);
    assign o_decode_flush = flush_all;
    assign o_alu2_flush   = flush_all;
    assign o_inv_inst     = ~inv_q[INV_DEPTH-1];

    // Retiring a long op with nothing outstanding would underflow the count.
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_reset)
        !(retire && !issue && lcnt_zero));

endmodule
